// File: rtl/zigbee_symbol_spreader.sv
// zigbee_symbol_spreader
// Takes a 16-bit payload word, walks the external 4:1 nibble mux through its
// four symbols and spreads each symbol into the 32-chip 802.15.4 PN sequence,
// one chip per chip-rate strobe.
module zigbee_symbol_spreader #(
  parameter int SYMB_PER_WORD  = 4,
  parameter int SEL_W          = 2,
  parameter int CHIPS_PER_SYMB = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inValid,
  input  logic [15:0]      inData,
  output logic             outReady,
  output logic [15:0]      outWord,
  output logic [SEL_W-1:0] outSel,
  input  logic [3:0]       inSymbol,
  input  logic             inChipEn,
  output logic             outChip,
  output logic             outChipValid,
  output logic             outBusy,
  output logic             outDone
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_SPREAD = 2'd2;

  localparam logic [4:0]       LAST_IDX = 5'(CHIPS_PER_SYMB - 1);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(SYMB_PER_WORD - 1);
  localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);

  // PN chip sequences, one 32-bit row per symbol; bit 31 is chip c0.
  localparam logic [15:0][31:0] CHIP_TABLE = {
    32'hC96077B8,  // 15
    32'h96077B8C,  // 14
    32'h6077B8C9,  // 13
    32'h077B8C96,  // 12
    32'h77B8C960,  // 11
    32'h7B8C9607,  // 10
    32'hB8C96077,  // 9
    32'h8C96077B,  // 8
    32'h9C3522ED,  // 7
    32'hC3522ED9,  // 6
    32'h3522ED9C,  // 5
    32'h522ED9C3,  // 4
    32'h22ED9C35,  // 3
    32'h2ED9C352,  // 2
    32'hED9C3522,  // 1
    32'hD9C3522E   // 0
  };

  logic [1:0]       state_q, state_d;
  logic [15:0]      word_q, word_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [4:0]       idx_q, idx_d;
  logic [3:0]       sym_q, sym_d;
  logic             pend_q, pend_d;
  logic             chip_q, chip_d;
  logic             chip_vld_q, chip_vld_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state logic: word accept, one-cycle symbol load, chip spreading.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    sel_d      = sel_q;
    idx_d      = idx_q;
    sym_d      = sym_q;
    pend_d     = pend_q;
    chip_d     = chip_q;
    chip_vld_d = 1'b0;
    ready_d    = ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (inValid && ready_q) begin
          word_d  = inData;
          sel_d   = '0;
          idx_d   = 5'd0;
          pend_d  = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        // The mux has had a full cycle to settle on the new select.
        sym_d   = inSymbol;
        state_d = S_SPREAD;
        if (inChipEn) begin
          pend_d = 1'b1;
        end else begin
          pend_d = 1'b0;
        end
      end
      S_SPREAD: begin
        if (inChipEn || pend_q) begin
          chip_d     = CHIP_TABLE[sym_q][5'd31 - idx_q];
          chip_vld_d = 1'b1;
          pend_d     = 1'b0;
          if (idx_q == LAST_IDX) begin
            idx_d = 5'd0;
            if (sel_q < LAST_SEL) begin
              sel_d   = sel_q + SEL_ONE;
              state_d = S_LOAD;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
              ready_d = 1'b1;
              busy_d  = 1'b0;
            end
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end else begin
          state_d = S_SPREAD;
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        pend_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any word in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      word_q     <= 16'h0000;
      sel_q      <= '0;
      idx_q      <= 5'd0;
      sym_q      <= 4'd0;
      pend_q     <= 1'b0;
      chip_q     <= 1'b0;
      chip_vld_q <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      sel_q      <= sel_d;
      idx_q      <= idx_d;
      sym_q      <= sym_d;
      pend_q     <= pend_d;
      chip_q     <= chip_d;
      chip_vld_q <= chip_vld_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign outReady     = ready_q;
  assign outWord      = word_q;
  assign outSel       = sel_q;
  assign outChip      = chip_q;
  assign outChipValid = chip_vld_q;
  assign outBusy      = busy_q;
  assign outDone      = done_q;

endmodule

// File: tb/tb_zigbee_symbol_spreader.sv
// Scoreboard bench for zigbee_symbol_spreader: a behavioural nibble mux feeds
// inSymbol, expected chips/selects are queued at word accept and compared as
// outChipValid pulses arrive.
module tb_zigbee_symbol_spreader;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inValid;
  logic [15:0] inData;
  logic        outReady;
  logic [15:0] outWord;
  logic [1:0]  outSel;
  logic [3:0]  inSymbol;
  logic        inChipEn;
  logic        outChip;
  logic        outChipValid;
  logic        outBusy;
  logic        outDone;

  typedef struct packed {
    logic       chip;
    logic [1:0] sel;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          chip_cnt = 0;
  int          done_cnt = 0;
  logic [31:0] cap;
  logic        force_en = 1'b0;
  logic [3:0]  force_sym = 4'd0;
  logic        stb_en = 1'b0;
  int          stb_period = 3;
  int          stb_cnt = 0;

  zigbee_symbol_spreader #(
    .SYMB_PER_WORD (4),
    .SEL_W         (2),
    .CHIPS_PER_SYMB(32)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .inValid     (inValid),
    .inData      (inData),
    .outReady    (outReady),
    .outWord     (outWord),
    .outSel      (outSel),
    .inSymbol    (inSymbol),
    .inChipEn    (inChipEn),
    .outChip     (outChip),
    .outChipValid(outChipValid),
    .outBusy     (outBusy),
    .outDone     (outDone)
  );

  always #5 clk = ~clk;

  // Behavioural 16-to-4 mux; select 0 returns the low nibble.
  always_comb begin
    case (outSel)
      2'd0:    inSymbol = outWord[3:0];
      2'd1:    inSymbol = outWord[7:4];
      2'd2:    inSymbol = outWord[11:8];
      default: inSymbol = outWord[15:12];
    endcase
    if (force_en) inSymbol = force_sym;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference PN sequence built from symbol 0 by rotation and odd-chip inversion.
  function automatic logic [31:0] exp_seq(input logic [3:0] s);
    logic [31:0] base;
    logic [31:0] v;
    int          sh;
    base = 32'hD9C3522E;
    sh   = 4 * int'(s[2:0]);
    v    = (sh == 0) ? base : ((base >> sh) | (base << (32 - sh)));
    if (s[3]) v = v ^ 32'h5555_5555;
    return v;
  endfunction

  task automatic push_word(input logic [15:0] syms);
    exp_t        e;
    logic [31:0] v;
    logic [3:0]  nib;
    for (int s = 0; s < 4; s++) begin
      nib = syms[4*s +: 4];
      v   = exp_seq(nib);
      for (int i = 0; i < 32; i++) begin
        e.chip = v[31-i];
        if (i == 31 && s < 3) e.sel = 2'(s + 1);
        else                  e.sel = 2'(s);
        sb.push_back(e);
      end
    end
  endtask

  // Chip-rate strobe generator, one clk wide, every stb_period cycles.
  initial begin
    inChipEn = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stb_en && stb_cnt >= stb_period - 1) begin
        inChipEn = 1'b1;
        stb_cnt  = 0;
      end else begin
        inChipEn = 1'b0;
        stb_cnt++;
      end
    end
  end

  // Output monitor: pops the scoreboard on every chip pulse.
  always @(negedge clk) begin
    exp_t e;
    if (outChipValid) begin
      check_eq("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_eq("chip", 32'(outChip), 32'(e.chip));
        check_eq("sel", 32'(outSel), 32'(e.sel));
      end
      if (chip_cnt < 32) cap[31-chip_cnt] = outChip;
      chip_cnt++;
    end
    if (outDone) done_cnt++;
  end

  task automatic clear_counts();
    chip_cnt = 0;
    done_cnt = 0;
    cap      = 32'h0;
  endtask

  task automatic send_word(input logic [15:0] data, input logic [15:0] syms, input logic hold);
    logic seen;
    seen = 1'b0;
    @(posedge clk);
    #1;
    inData  = data;
    inValid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (outReady) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("accept_timeout", 32'(seen), 32'd1);
    push_word(syms);
    @(posedge clk);
    #1;
    if (!hold) inValid = 1'b0;
    @(negedge clk);
    check_eq("ready_low", 32'(outReady), 32'd0);
    check_eq("busy_high", 32'(outBusy), 32'd1);
    check_eq("word_held", 32'(outWord), 32'(data));
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (outDone) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("done_timeout", 32'(seen), 32'd1);
    check_eq("ready_with_done", 32'(outReady), 32'd1);
    check_eq("busy_with_done", 32'(outBusy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, 32'(outReady), 32'd1);
    check_eq({tag, "_word"}, 32'(outWord), 32'd0);
    check_eq({tag, "_sel"}, 32'(outSel), 32'd0);
    check_eq({tag, "_chip"}, 32'(outChip), 32'd0);
    check_eq({tag, "_cv"}, 32'(outChipValid), 32'd0);
    check_eq({tag, "_busy"}, 32'(outBusy), 32'd0);
    check_eq({tag, "_done"}, 32'(outDone), 32'd0);
  endtask

  initial begin
    logic seen;
    resetn  = 1'b0;
    inValid = 1'b0;
    inData  = 16'h0000;
    clear_counts();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Strobes in IDLE with no word are ignored.
    stb_en     = 1'b1;
    stb_period = 2;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_eq("idle_cv_cnt", 32'(chip_cnt), 32'd0);
    check_eq("idle_chip", 32'(outChip), 32'd0);
    check_eq("idle_ready", 32'(outReady), 32'd1);

    // Word 0x0000 at maximum strobe rate: strobes also land on LOAD cycles.
    clear_counts();
    send_word(16'h0000, 16'h0000, 1'b0);
    wait_done();
    @(negedge clk);
    check_eq("done_single", 32'(outDone), 32'd0);
    check_eq("w0_first32", cap, 32'hD9C3522E);
    check_eq("w0_chips", 32'(chip_cnt), 32'd128);
    check_eq("w0_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("w0_sb_empty", 32'(sb.size()), 32'd0);

    // Forced symbol 1.
    clear_counts();
    force_en  = 1'b1;
    force_sym = 4'd1;
    stb_period = 3;
    send_word(16'hA5A5, 16'h1111, 1'b0);
    wait_done();
    @(posedge clk);
    #2;
    check_eq("s1_first32", cap, 32'hED9C3522);
    check_eq("s1_chips", 32'(chip_cnt), 32'd128);

    // Forced symbol 8: symbol 0 with odd-index chips inverted.
    clear_counts();
    force_sym  = 4'd8;
    stb_period = 5;
    send_word(16'h0F0F, 16'h8888, 1'b0);
    wait_done();
    @(posedge clk);
    #2;
    check_eq("s8_first32", cap, 32'h8C96077B);
    check_eq("s8_chips", 32'(chip_cnt), 32'd128);
    force_en = 1'b0;

    // Mixed symbols, inValid held high across two words.
    clear_counts();
    stb_period = 2;
    send_word(16'h9C3F, 16'h9C3F, 1'b1);
    inData = 16'h71E6;
    @(negedge clk);
    check_eq("word_stable", 32'(outWord), 32'h9C3F);
    wait_done();
    push_word(16'h71E6);
    @(posedge clk);
    #1;
    inValid = 1'b0;
    @(negedge clk);
    check_eq("b2b_ready_low", 32'(outReady), 32'd0);
    check_eq("b2b_word", 32'(outWord), 32'h71E6);
    wait_done();
    @(posedge clk);
    #2;
    check_eq("b2b_chips", 32'(chip_cnt), 32'd256);
    check_eq("b2b_done_cnt", 32'(done_cnt), 32'd2);
    check_eq("b2b_sb_empty", 32'(sb.size()), 32'd0);

    // Reset in the middle of a word.
    clear_counts();
    stb_period = 3;
    send_word(16'h4D2B, 16'h4D2B, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (chip_cnt >= 50) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("chip50_timeout", 32'(seen), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    check_eq("midrst_no_done", 32'(done_cnt), 32'd0);

    // Fresh word after the abandoned one restarts from select 0, chip 0.
    clear_counts();
    send_word(16'hE07B, 16'hE07B, 1'b0);
    wait_done();
    @(posedge clk);
    #2;
    check_eq("post_first32", cap, exp_seq(4'hB));
    check_eq("post_chips", 32'(chip_cnt), 32'd128);
    check_eq("post_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("post_sb_empty", 32'(sb.size()), 32'd0);

    stb_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
